// File: rtl/shift_pkg.sv
// shift_pkg: shift mode and sequencer state encodings shared by the shift datapaths
package shift_pkg;
  localparam logic [1:0] SHR_LOGIC = 2'b00;
  localparam logic [1:0] SHR_ARITH = 2'b01;
  localparam logic [1:0] SHR_ROT   = 2'b10;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/seq_shift_right_if.sv
// seq_shift_right_if: start/busy/done request bus between control unit and right shifter
interface seq_shift_right_if #(parameter int W = 16);
  localparam int SW = $clog2(W);
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  data_in;
  logic [SW-1:0] shamt;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  modport master (output start, mode, data_in, shamt, input busy, done, result);
  modport slave (input start, mode, data_in, shamt, output busy, done, result);
endinterface

// File: rtl/shift_right_1.sv
// shift_right_1: single-step right shift; rotate only exists when SHR_ROTATE_EN is defined
module shift_right_1
  import shift_pkg::*;
#(parameter int W = 16) (
  input  logic [W-1:0] value,
  input  logic [1:0]   mode,
  output logic [W-1:0] shifted
);
`ifdef SHR_ROTATE_EN
  always_comb shifted = (mode == SHR_ARITH) ? {value[W-1], value[W-1:1]} :
                        (mode == SHR_ROT)   ? {value[0], value[W-1:1]} : value >> 1;
`else
  always_comb shifted = (mode == SHR_ARITH) ? {value[W-1], value[W-1:1]} : value >> 1;
`endif
endmodule

// File: rtl/seq_shift_right.sv
// seq_shift_right: multi-cycle right shifter, one bit per clock (rotate via SHR_ROTATE_EN)
module seq_shift_right
  import shift_pkg::*;
#(parameter int W = 16) (
  input logic clk,
  input logic rst,
  seq_shift_right_if.slave bus
);
  localparam int SW = $clog2(W);
  state_t        state, state_n;
  logic [W-1:0]  result, stepped;
  logic [SW-1:0] count;
  logic [1:0]    mode_q;
  logic          accept;
  shift_right_1 #(.W(W)) u_step (.value(result), .mode(mode_q), .shifted(stepped));
  // DONE is as ready as IDLE, which is what makes back-to-back starts possible
  always_comb begin
    accept  = bus.start && (state != SHIFT);
    state_n = (state == SHIFT) ? ((count == SW'(1)) ? DONE : SHIFT) :
              accept ? ((bus.shamt != '0) ? SHIFT : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      mode_q <= SHR_LOGIC;
    end else begin
      state <= state_n;
      if (accept) begin
        result <= bus.data_in;
        count  <= bus.shamt;
        mode_q <= bus.mode;
      end else if (state == SHIFT) begin
        result <= stepped;
        count  <= count - SW'(1);
      end
    end
  end
  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);
  assign bus.result = result;
endmodule

// File: tb/tb_seq_shift_right.sv
// tb_seq_shift_right: vector table plus scoreboard queue checked on every done pulse
module tb_seq_shift_right;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  seq_shift_right_if #(.W(16)) bus();
  seq_shift_right #(.W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef SHR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [3:0]  shamt;
    logic [15:0] exp;
    string       name;
  } vec_t;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) check("unexpected_done", 16'(bus.done), 16'h0);
      else check("scoreboard_result", bus.result, sb.pop_front());
    end
  end
  task automatic run_op(input logic [1:0] m, input logic [15:0] d, input logic [3:0] s,
                        input logic [15:0] e, input string name);
    int cyc = 0;
    sb.push_back(e);
    bus.start = 1; bus.mode = m; bus.data_in = d; bus.shamt = s;
    @(posedge clk); #1;
    bus.start = 0; bus.data_in = 16'($urandom); bus.shamt = 4'($urandom); bus.mode = 2'($urandom);
    do begin
      @(negedge clk); cyc++;
      if (!bus.done) check({name, "_busy"}, 16'(bus.busy), 16'(cyc <= int'(s)));
    end while (!bus.done && cyc < 40);
    check({name, "_latency"}, 16'(cyc), 16'(int'(s) + 1));
    check({name, "_busy_at_done"}, 16'(bus.busy), 16'h0);
    @(negedge clk);
    check({name, "_held"}, bus.result, e);
    check({name, "_done_one_cycle"}, 16'(bus.done), 16'h0);
  endtask
  initial begin
    vec_t vecs[9];
    int cyc;
    int pulses;
    vecs = '{
      '{2'b00, 16'hF0F0, 4'd4,  16'h0F0F, "logic_f0f0"},
      '{2'b01, 16'h8000, 4'd15, 16'hFFFF, "arith_max"},
      '{2'b00, 16'h8000, 4'd15, 16'h0001, "logic_max"},
      '{2'b00, 16'h1234, 4'd0,  16'h1234, "zero_amount"},
      '{2'b10, 16'h0001, 4'd1,  ROT ? 16'h8000 : 16'h0000, "rotate_1"},
      '{2'b10, 16'h1234, 4'd4,  ROT ? 16'h4123 : 16'h0123, "rotate_4"},
      '{2'b11, 16'h8001, 4'd1,  16'h4000, "reserved_mode"},
      '{2'b01, 16'h7FFE, 4'd3,  16'h0FFF, "arith_pos"},
      '{2'b01, 16'hF000, 4'd4,  16'hFF00, "arith_neg"}
    };
    bus.start = 0; bus.mode = 0; bus.data_in = 0; bus.shamt = 0;
    repeat (2) @(negedge clk);
    check("reset_busy", 16'(bus.busy), 16'h0);
    check("reset_done", 16'(bus.done), 16'h0);
    check("reset_result", bus.result, 16'h0);
    rst = 0;
    @(negedge clk);
    foreach (vecs[i]) run_op(vecs[i].mode, vecs[i].data, vecs[i].shamt, vecs[i].exp, vecs[i].name);
    // start while busy must be ignored
    sb.push_back(16'h0246);
    bus.start = 1; bus.mode = 2'b00; bus.data_in = 16'h1230; bus.shamt = 4'd3;
    @(posedge clk); #1 bus.start = 0;
    @(negedge clk);
    bus.start = 1; bus.data_in = 16'hFFFF; bus.shamt = 4'd1;
    @(posedge clk); #1 bus.start = 0;
    cyc = 1;
    do begin @(negedge clk); cyc++; end while (!bus.done && cyc < 40);
    check("busy_start_latency", 16'(cyc), 16'd4);
    @(negedge clk);
    check("busy_start_idle", 16'(bus.busy), 16'h0);
    // reset in the middle of a shift
    bus.start = 1; bus.mode = 2'b00; bus.data_in = 16'hFFFF; bus.shamt = 4'd10;
    @(posedge clk); #1 bus.start = 0;
    repeat (3) @(negedge clk);
    check("midop_busy_before", 16'(bus.busy), 16'h1);
    rst = 1;
    @(negedge clk);
    check("midop_busy", 16'(bus.busy), 16'h0);
    check("midop_done", 16'(bus.done), 16'h0);
    check("midop_result", bus.result, 16'h0);
    rst = 0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (bus.done) pulses++; end
    check("midop_no_done", 16'(pulses), 16'h0);
    run_op(2'b00, 16'h00FF, 4'd4, 16'h000F, "after_reset");
    // back-to-back: new start during DONE
    sb.push_back(16'h003C);
    sb.push_back(16'h5555);
    bus.start = 1; bus.mode = 2'b00; bus.data_in = 16'h00F0; bus.shamt = 4'd2;
    @(posedge clk); #1 bus.start = 0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.done && cyc < 40);
    check("b2b_first_latency", 16'(cyc), 16'd3);
    bus.start = 1; bus.mode = 2'b00; bus.data_in = 16'hAAAA; bus.shamt = 4'd1;
    @(posedge clk); #1 bus.start = 0;
    @(negedge clk);
    check("b2b_cycle1_busy", 16'(bus.busy), 16'h1);
    @(negedge clk);
    check("b2b_cycle2_done", 16'(bus.done), 16'h1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
